mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Parametrised memory-mapped I/O bridge between the CPU data path and N board-level I/O channels; it generalises the single 16-bit fixed I/O port of the current core. The CPU issues one load/store per request, the bridge decodes the channel, applies a configurable number of wait states while holding `stall`, and returns a one-cycle response. Inputs pass through 2-flop synchronisers. Outputs are held in per-channel registers with write strobes.

## Interface
Parameters:
- `DATA_W`, 32: CPU data width.
- `IO_W`, 16: per-channel I/O width, ≤ `DATA_W`.
- `N_CH`, 4: channel count, 1..16.
- `BASE_ADDR`, 32'hFFFF_FC00: byte address of channel 0.
- `WAIT_CYCLES`, 1: wait states per access, 0..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: core clock (the divided CPU clock).
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: CPU access request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in `DATA_W`: store data.
- `stall` out 1: bridge busy; the CPU freezes its PC and operands while this is high.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out `DATA_W`: load data, zero-extended.
- `resp_err` out 1: decode error, qualified by `resp_valid`.
- `io_in` in `N_CH*IO_W`: raw asynchronous inputs (switches); channel k occupies bits [k*IO_W +: IO_W].
- `io_out` out `N_CH*IO_W`: registered outputs (LEDs, segments).
- `io_wstb` out `N_CH`: one-cycle pulse on the cycle channel k's output register updates.

## Operation
- Address map:
  - Channel k is at `BASE_ADDR + 4*k`.
  - Valid iff `req_addr[1:0]==0`, `req_addr >= BASE_ADDR`, and index < `N_CH`.
  - Anything else is an error.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on `req_valid`=1, latch addr/write/wdata and decode. Go to WAIT if `WAIT_CYCLES`>0, else to RESP. Load the wait counter with `WAIT_CYCLES-1`.
  - WAIT: decrement the counter. At 0, go to RESP.
  - RESP: assert `resp_valid` for one cycle, then return to IDLE.
- Store, valid address:
  - On the RESP cycle, `io_out` channel k ← `req_wdata[IO_W-1:0]` and `io_wstb[k]`=1.
  - Upper data bits are ignored.
- Load, valid address:
  - `resp_rdata` = zero-extended synchronised `io_in` channel k, sampled on the edge entering RESP.
- Error:
  - `resp_err`=1, `resp_rdata`=0.
  - No `io_out` change and no strobe.
- `stall`:
  - Combinationally high in IDLE when `req_valid`=1.
  - High throughout WAIT.
  - Low in RESP and otherwise.
- `req_valid` seen outside IDLE is ignored. A new request may be accepted on the cycle after RESP.
- Synchroniser: 2 flops per bit, always running, independent of the FSM.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `io_out`=0, `io_wstb`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - Synchroniser flops 0.
  - `stall`=0 while `req_valid`=0.
- Latency from accept edge to `resp_valid` high is `WAIT_CYCLES`+1 cycles. With `WAIT_CYCLES`=1, the request is in cycle 0 and the response in cycle 2.
- Input-to-read latency: an `io_in` change is visible to a load whose RESP-entry edge is ≥2 edges after the change.
- `io_out` changes on the RESP-entry edge together with `io_wstb`. `io_wstb` deasserts on the next edge.
- Reset asserted mid-access: abort immediately. No response is produced and no write occurs.
- `resp_rdata` and `resp_err` hold their values until the next RESP.

## Structure
- Package `mmio_pkg`:
  - FSM state enum (IDLE/WAIT/RESP).
  - Default `BASE_ADDR`.
  - Channel stride constant (4).
- Sub-module `sync2` (parametrised width, 2-flop, async reset to 0). Instantiate it once over the full `io_in` vector.
- Decode, FSM, counter and output registers stay in the top module.

## Test plan
- Reset then idle: all outputs 0 and `stall`=0. Drive `io_in` with `reset` high → nothing propagates.
- Store 32'hABCD_1234 to `BASE_ADDR+4`, defaults:
  - `stall` is high for 2 cycles.
  - `io_out[31:16]`=16'h1234.
  - `io_wstb`=4'b0010 for 1 cycle.
  - `resp_valid` occurs exactly 2 cycles after accept.
- `io_in` ch2 = 16'h00F5, wait 3 cycles, load `BASE_ADDR+8` → `resp_rdata`=32'h0000_00F5, `resp_err`=0.
- Error cases, each → `resp_err`=1, `resp_rdata`=0, `io_out` unchanged, no strobe:
  - Load `BASE_ADDR+16` with `N_CH`=4.
  - Store to `BASE_ADDR+2`.
  - Access to `BASE_ADDR-4`.
- `WAIT_CYCLES`=0 build:
  - Back-to-back stores to ch0 then ch3 → responses exactly 2 cycles apart.
  - `req_valid` held high during RESP is not double-accepted.
- Assert `reset` during WAIT of a store to ch1 → no `resp_valid`, `io_out` ch1 remains 0, FSM is IDLE after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the mmio_bridge block.
//   state_e            bridge FSM state (idle / wait states / response)
//   acc_t              decoded access held across the wait states
//   DEFAULT_BASE_ADDR  byte address of channel 0
//   CH_STRIDE          byte distance between consecutive channels
package mmio_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned CNT_W     = 4;   // wait-state counter, 0..15
    localparam int unsigned IDX_W     = 4;   // channel index, up to 16 channels
    localparam int unsigned CH_STRIDE = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'hFFFF_FC00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic             write;
        logic             err;
        logic [IDX_W-1:0] idx;
    } acc_t;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser per bit, asynchronously cleared.
//   clk, reset  clock and async active-high reset
//   d           asynchronous input vector
//   q           synchronised output vector (two edges of latency)
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU load/store to N_CH board I/O channels with wait states.
//   clk, reset                  core clock, async active-high reset
//   req_valid/write/addr/wdata  one CPU access per request
//   stall                       CPU freeze while the access is pending (combinational)
//   resp_valid/rdata/err        one-cycle response; rdata/err hold until next response
//   io_in                       raw async inputs, channel k at [k*IO_W +: IO_W]
//   io_out, io_wstb             registered outputs and per-channel update strobes
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       IO_W        = 16,
    parameter int unsigned       N_CH        = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned       WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   stall,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    input  logic [N_CH*IO_W-1:0]   io_in,
    output logic [N_CH*IO_W-1:0]   io_out,
    output logic [N_CH-1:0]        io_wstb
);

    localparam int unsigned IOV_W     = N_CH * IO_W;
    localparam int unsigned STRIDE_LG = $clog2(CH_STRIDE);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    acc_t              acc_q, acc_d;
    logic [IO_W-1:0]   wdata_q, wdata_d;
    logic [IOV_W-1:0]  io_out_q, io_out_d;
    logic [N_CH-1:0]   io_wstb_q, io_wstb_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [IOV_W-1:0]  io_sync;
    logic [ADDR_W-1:0] offset_c;
    logic [ADDR_W-1:0] word_c;
    logic [IDX_W-1:0]  dec_idx;
    logic              dec_ok;
    logic              stall_c;
    logic              enter_resp;
    logic [IO_W-1:0]   rd_sel;

    // Input synchroniser, free-running over the whole io_in vector.
    sync2 #(.WIDTH(IOV_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (io_in),
        .q     (io_sync)
    );

    // Upper store data bits never reach a channel.
    if (DATA_W > IO_W) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^req_wdata[DATA_W-1:IO_W];
    end

    // Address decode: aligned, at or above the base, and inside the channel range.
    always_comb begin
        offset_c = req_addr - BASE_ADDR;
        word_c   = offset_c >> STRIDE_LG;
        dec_idx  = word_c[IDX_W-1:0];
        dec_ok   = (req_addr[STRIDE_LG-1:0] == '0)
                && (req_addr >= BASE_ADDR)
                && (word_c < ADDR_W'(N_CH));
    end

    // FSM next state plus the response/output register updates on RESP entry.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        wdata_d      = wdata_q;
        io_out_d     = io_out_q;
        io_wstb_d    = '0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        stall_c      = 1'b0;
        enter_resp   = 1'b0;
        rd_sel       = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    stall_c = 1'b1;
                    acc_d   = '{write: req_write, err: ~dec_ok, idx: dec_idx};
                    wdata_d = req_wdata[IO_W-1:0];
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // acc_d covers both the zero-wait path (fresh decode) and the WAIT path (held).
        for (int k = 0; k < int'(N_CH); k++) begin
            if (acc_d.idx == IDX_W'(k)) begin
                rd_sel = io_sync[k*IO_W +: IO_W];
            end
        end

        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = acc_d.err;
            resp_rdata_d = '0;
            if (!acc_d.err) begin
                if (acc_d.write) begin
                    for (int k = 0; k < int'(N_CH); k++) begin
                        if (acc_d.idx == IDX_W'(k)) begin
                            io_out_d[k*IO_W +: IO_W] = wdata_d;
                            io_wstb_d[k]             = 1'b1;
                        end
                    end
                end else begin
                    resp_rdata_d = DATA_W'(rd_sel);
                end
            end
        end
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            wdata_q      <= '0;
            io_out_q     <= '0;
            io_wstb_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            wdata_q      <= wdata_d;
            io_out_q     <= io_out_d;
            io_wstb_q    <= io_wstb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign stall      = stall_c;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign io_out     = io_out_q;
    assign io_wstb    = io_wstb_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: self-checking bench for mmio_bridge (default build and a
// zero-wait-state build sharing clock, reset and io_in).
module tb_mmio_bridge;

    localparam int unsigned    N_CH = 4;
    localparam logic [31:0]    BASE = 32'hFFFF_FC00;
    localparam int unsigned    NV   = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic        rand_io;
    logic [63:0] io_set, io_rand, io_in;

    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        stall, resp_valid, resp_err;
    logic [63:0] io_out;
    logic [3:0]  io_wstb;

    logic        req_valid_z, req_write_z;
    logic [31:0] req_addr_z, req_wdata_z, resp_rdata_z;
    logic        stall_z, resp_valid_z, resp_err_z;
    logic [63:0] io_out_z;
    logic [3:0]  io_wstb_z;

    int checks = 0;
    int errors = 0;

    // Observations from the last access on the default bridge.
    int          ob_lat, ob_stalls;
    logic        ob_stall_resp, ob_err;
    logic [31:0] ob_rd;
    logic [3:0]  ob_wstb;
    logic [63:0] ob_iout, ob_in;
    logic [4:0]  ob_after;

    // Model of the synchroniser: value a load sees is io_in as sampled two edges earlier.
    logic [63:0] hist[$];
    logic [63:0] io_model;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [63:0] iin;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        logic [3:0]  wstb;
        logic [63:0] iout;
    } vec_t;
    vec_t vec[NV];

    always #5 clk = ~clk;

    assign io_in = rand_io ? io_rand : io_set;

    mmio_bridge u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_wstb    (io_wstb)
    );

    mmio_bridge #(.WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_z),
        .req_write  (req_write_z),
        .req_addr   (req_addr_z),
        .req_wdata  (req_wdata_z),
        .stall      (stall_z),
        .resp_valid (resp_valid_z),
        .resp_rdata (resp_rdata_z),
        .resp_err   (resp_err_z),
        .io_in      (io_in),
        .io_out     (io_out_z),
        .io_wstb    (io_wstb_z)
    );

    initial begin
        io_rand = '0;
        forever begin
            @(negedge clk);
            io_rand = {$urandom(), $urandom()};
        end
    end

    initial begin
        hist = '{64'd0, 64'd0, 64'd0};
        forever begin
            @(posedge clk);
            if (reset) hist = '{64'd0, 64'd0, 64'd0};
            else begin
                hist.push_back(io_in);
                if (hist.size() > 4) void'(hist.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [63:0] iin, input logic err, input logic chk_rd,
                                input logic [31:0] rd, input logic [3:0] wstb, input logic [63:0] iout);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.iin = iin; v.err = err;
        v.chk_rd = chk_rd; v.rd = rd; v.wstb = wstb; v.iout = iout;
        return v;
    endfunction

    // Channel decode from the address-map rules, in plain integer arithmetic.
    function automatic void ref_decode(input logic [31:0] a, output logic ok, output int ch);
        longint off;
        off = longint'(a) - longint'(BASE);
        ok  = (a % 4 == 0) && (off >= 0) && (off / 4 < longint'(N_CH));
        ch  = ok ? int'(off / 4) : 0;
    endfunction

    // One access on the default bridge, recording what happened at the response.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        #1;
        ob_stalls = stall ? 1 : 0;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        cyc = 1;
        while (!resp_valid && cyc < 32) begin
            if (stall) ob_stalls++;
            @(negedge clk);
            cyc++;
        end
        ob_lat        = cyc;
        ob_stall_resp = stall;
        ob_rd         = resp_rdata;
        ob_err        = resp_err;
        ob_wstb       = io_wstb;
        ob_iout       = io_out;
        ob_in         = hist[hist.size()-3];
        @(negedge clk);
        ob_after = {resp_valid, io_wstb};
    endtask

    task automatic judge(input string nm, input logic ex_err, input logic chk_rd,
                         input logic [31:0] ex_rd, input logic [3:0] ex_wstb, input logic [63:0] ex_iout);
        check({nm, " latency"}, 64'(ob_lat), 64'd2);
        check({nm, " stall cycles"}, 64'(ob_stalls), 64'd2);
        check({nm, " stall in resp"}, 64'(ob_stall_resp), 64'd0);
        check({nm, " err"}, 64'(ob_err), 64'(ex_err));
        if (chk_rd) check({nm, " rdata"}, 64'(ob_rd), 64'(ex_rd));
        check({nm, " wstb"}, 64'(ob_wstb), 64'(ex_wstb));
        check({nm, " io_out"}, ob_iout, ex_iout);
        check({nm, " pulse end"}, 64'(ob_after), 64'd0);
    endtask

    initial begin
        logic        ok, w;
        int          ch, kind;
        logic [31:0] a, d, ex_rd;
        logic [3:0]  ex_wstb;

        reset = 1'b1; rand_io = 1'b0; io_set = '1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        req_valid_z = 0; req_write_z = 0; req_addr_z = '0; req_wdata_z = '0;

        // Reset with inputs driven: outputs quiet, synchroniser must not capture.
        repeat (3) @(negedge clk);
        check("rst io_out", io_out, 64'd0);
        check("rst wstb", 64'(io_wstb), 64'd0);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst rdata", 64'(resp_rdata), 64'd0);
        check("rst err", 64'(resp_err), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst io_out z", io_out_z, 64'd0);
        reset = 1'b0; io_set = '0;
        req_valid_z = 1'b1; req_write_z = 1'b0; req_addr_z = BASE;
        @(negedge clk);
        req_valid_z = 1'b0;
        check("rst sync valid z", 64'(resp_valid_z), 64'd1);
        check("rst sync rdata z", 64'(resp_rdata_z), 64'd0);

        // Reset during WAIT of a store to ch1: abort without response or write.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = BASE + 32'd4; req_wdata = 32'h0000_5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort stall in wait", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        check("abort stall after reset", 64'(stall), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort resp_valid", 64'(resp_valid), 64'd0);
            check("abort wstb", 64'(io_wstb), 64'd0);
            check("abort io_out", io_out, 64'd0);
        end
        reset = 1'b0;
        access(1'b0, BASE + 32'd4, 32'd0);
        judge("abort idle", 1'b0, 1'b1, 32'd0, 4'd0, 64'd0);

        // Directed vectors on the default build.
        vec[0]  = mk(1, BASE + 32'd4,  32'hABCD_1234, 64'h1111_00F5_2222_3333, 0, 0, 32'h0, 4'b0010, 64'h0000_0000_1234_0000);
        vec[1]  = mk(0, BASE + 32'd8,  32'h0,         64'h1111_00F5_2222_3333, 0, 1, 32'h0000_00F5, 4'b0000, 64'h0000_0000_1234_0000);
        vec[2]  = mk(0, BASE + 32'd16, 32'h0,         64'h1111_00F5_2222_3333, 1, 1, 32'h0, 4'b0000, 64'h0000_0000_1234_0000);
        vec[3]  = mk(1, BASE + 32'd2,  32'hFFFF_FFFF, 64'h1111_00F5_2222_3333, 1, 1, 32'h0, 4'b0000, 64'h0000_0000_1234_0000);
        vec[4]  = mk(0, BASE - 32'd4,  32'h0,         64'h1111_00F5_2222_3333, 1, 1, 32'h0, 4'b0000, 64'h0000_0000_1234_0000);
        vec[5]  = mk(1, BASE + 32'd12, 32'h0000_BEEF, 64'h1111_00F5_2222_3333, 0, 0, 32'h0, 4'b1000, 64'hBEEF_0000_1234_0000);
        vec[6]  = mk(0, BASE,          32'h0,         64'h1111_00F5_2222_A5A5, 0, 1, 32'h0000_A5A5, 4'b0000, 64'hBEEF_0000_1234_0000);
        vec[7]  = mk(1, BASE - 32'd4,  32'h0000_0001, 64'h1111_00F5_2222_A5A5, 1, 1, 32'h0, 4'b0000, 64'hBEEF_0000_1234_0000);
        vec[8]  = mk(0, 32'hFFFF_FFFC, 32'h0,         64'h1111_00F5_2222_A5A5, 1, 1, 32'h0, 4'b0000, 64'hBEEF_0000_1234_0000);
        vec[9]  = mk(1, BASE,          32'h7777_0001, 64'h1111_00F5_2222_A5A5, 0, 0, 32'h0, 4'b0001, 64'hBEEF_0000_1234_0001);
        vec[10] = mk(0, BASE + 32'd12, 32'h0,         64'h8000_00F5_2222_A5A5, 0, 1, 32'h0000_8000, 4'b0000, 64'hBEEF_0000_1234_0001);
        for (int i = 0; i < int'(NV); i++) begin
            io_set = vec[i].iin;
            repeat (3) @(negedge clk);
            access(vec[i].w, vec[i].a, vec[i].d);
            judge($sformatf("vec%0d", i), vec[i].err, vec[i].chk_rd, vec[i].rd, vec[i].wstb, vec[i].iout);
        end
        io_model = vec[NV-1].iout;

        // Zero-wait build: back-to-back stores, request held through RESP.
        @(negedge clk);
        req_valid_z = 1'b1; req_write_z = 1'b1; req_addr_z = BASE; req_wdata_z = 32'hFFFF_1111;
        #1;
        check("wc0 stall accept", 64'(stall_z), 64'd1);
        @(negedge clk);
        check("wc0 resp1 valid", 64'(resp_valid_z), 64'd1);
        check("wc0 resp1 wstb", 64'(io_wstb_z), 64'b0001);
        check("wc0 resp1 stall", 64'(stall_z), 64'd0);
        check("wc0 resp1 io_out", io_out_z, 64'h0000_0000_0000_1111);
        @(negedge clk);
        check("wc0 no double accept", 64'(resp_valid_z), 64'd0);
        check("wc0 no double wstb", 64'(io_wstb_z), 64'd0);
        req_addr_z = BASE + 32'd12; req_wdata_z = 32'h0000_2222;
        @(negedge clk);
        req_valid_z = 1'b0;
        check("wc0 resp2 valid", 64'(resp_valid_z), 64'd1);
        check("wc0 resp2 wstb", 64'(io_wstb_z), 64'b1000);
        check("wc0 resp2 io_out", io_out_z, 64'h2222_0000_0000_1111);
        check("wc0 resp2 err", 64'(resp_err_z), 64'd0);
        @(negedge clk);
        check("wc0 idle valid", 64'(resp_valid_z), 64'd0);

        // Randomised accesses against the address-map model, io_in changing every cycle.
        rand_io = 1'b1;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, N_CH - 1));
                3:       a = BASE + 32'(4 * $urandom_range(N_CH, N_CH + 4));
                4:       a = BASE + 32'($urandom_range(0, 4 * N_CH - 1));
                default: a = BASE - 32'(4 * $urandom_range(1, 8));
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom();
            ref_decode(a, ok, ch);
            access(w, a, d);
            ex_wstb = '0;
            ex_rd   = '0;
            if (ok && w) begin
                io_model[ch*16 +: 16] = d[15:0];
                ex_wstb = 4'(1 << ch);
            end else if (ok) begin
                ex_rd = {16'h0, ob_in[ch*16 +: 16]};
            end
            judge($sformatf("rnd%0d", i), !ok, !(ok && w), ex_rd, ex_wstb, io_model);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
